// File: rtl/mvm_uart_ctrl.sv
// mvm_uart_ctrl
//
// Sits between a byte-wide UART and a matrix-vector-multiply engine.
// Collects one {k,x} operand frame from the RX byte stream, presents it to
// the engine as a single wide word, waits for the row results, and streams
// them back out as sign-extended little-endian words on the TX byte stream.
// A frame that stalls mid-way for TIMEOUT cycles is dropped and flagged on
// err so the host can resynchronise by simply resending.

module mvm_uart_ctrl #(
    parameter  int R             = 4,
    parameter  int C             = 4,
    parameter  int W_X           = 8,
    parameter  int W_K           = 8,
    parameter  int W_Y_OUT       = 32,
    parameter  int BITS_PER_WORD = 8,
    parameter  int TIMEOUT       = 1024,
    localparam int W_Y           = W_X + W_K + $clog2(C),
    localparam int W_BUS_KX      = R*C*W_K + C*W_X,
    localparam int N_WORDS_KX    = W_BUS_KX / BITS_PER_WORD,
    localparam int N_WORDS_Y     = R*W_Y_OUT / BITS_PER_WORD
) (
    input  logic                     clk,
    input  logic                     rst,

    // byte stream from UART RX
    input  logic                     s_valid,
    input  logic [BITS_PER_WORD-1:0] s_data,
    output logic                     s_ready,

    // operand bus to the MVM engine, x in the LSBs
    output logic                     kx_valid,
    output logic [W_BUS_KX-1:0]      kx_data,
    input  logic                     kx_ready,

    // signed row results from the engine, row 0 in the LSBs
    input  logic                     y_valid,
    input  logic [R*W_Y-1:0]         y_data,
    output logic                     y_ready,

    // byte stream to UART TX
    output logic                     m_valid,
    output logic [BITS_PER_WORD-1:0] m_data,
    input  logic                     m_ready,

    output logic                     busy,
    output logic                     err
);

    localparam int RX_CNT_W = $clog2(N_WORDS_KX + 1);
    localparam int TX_CNT_W = $clog2(N_WORDS_Y + 1);
    localparam int TO_CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [RX_CNT_W-1:0] RX_LAST = RX_CNT_W'(N_WORDS_KX - 1);
    localparam logic [TX_CNT_W-1:0] TX_LAST = TX_CNT_W'(N_WORDS_Y - 1);
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_RX     = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_WAIT_Y = 2'd2;
    localparam logic [1:0] ST_TX     = 2'd3;

    logic [1:0]              state;
    logic [RX_CNT_W-1:0]     rx_cnt;
    logic [TX_CNT_W-1:0]     tx_cnt;
    logic [TO_CNT_W-1:0]     to_cnt;
    logic [W_BUS_KX-1:0]     kx_buf;
    logic [R*W_Y_OUT-1:0]    tx_buf;

    logic                    s_fire;
    logic                    kx_fire;
    logic                    y_fire;
    logic                    m_fire;

    // s_ready depends on state only, so RX never sees a combinational path
    // from its own s_valid back into s_ready.
    always_comb begin
        s_ready = (state == ST_RX);
        busy    = !((state == ST_RX) && (rx_cnt == '0));
        kx_data = kx_buf;
        s_fire  = s_valid  && s_ready;
        kx_fire = kx_valid && kx_ready;
        y_fire  = y_valid  && y_ready;
        m_fire  = m_valid  && m_ready;
    end

    // Frame sequencing: counters, registered handshake flags and abort pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RX;
            rx_cnt   <= '0;
            tx_cnt   <= '0;
            to_cnt   <= '0;
            kx_valid <= 1'b0;
            y_ready  <= 1'b0;
            m_valid  <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_RX: begin
                    // an accepted byte always beats the timeout on the same cycle
                    if (s_fire) begin
                        to_cnt <= '0;
                        if (rx_cnt == RX_LAST) begin
                            rx_cnt   <= '0;
                            state    <= ST_REQ;
                            kx_valid <= 1'b1;
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end else if (rx_cnt != '0) begin
                        if (to_cnt == TO_LAST) begin
                            rx_cnt <= '0;
                            to_cnt <= '0;
                            err    <= 1'b1;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (kx_fire) begin
                        kx_valid <= 1'b0;
                        y_ready  <= 1'b1;
                        state    <= ST_WAIT_Y;
                    end
                end
                ST_WAIT_Y: begin
                    if (y_fire) begin
                        y_ready <= 1'b0;
                        m_valid <= 1'b1;
                        state   <= ST_TX;
                    end
                end
                ST_TX: begin
                    if (m_fire) begin
                        if (tx_cnt == TX_LAST) begin
                            tx_cnt  <= '0;
                            m_valid <= 1'b0;
                            state   <= ST_RX;
                        end else begin
                            tx_cnt <= tx_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_RX;
                end
            endcase
        end
    end

    // Operand buffer: each accepted RX byte lands in slot rx_cnt.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N_WORDS_KX; i++) begin
            if (s_fire && (rx_cnt == RX_CNT_W'(i))) begin
                kx_buf[i*BITS_PER_WORD +: BITS_PER_WORD] <= s_data;
            end
        end
    end

    // Result buffer: every row is sign-extended to the wire width on capture.
    always_ff @(posedge clk) begin
        if (y_fire) begin
            for (int unsigned r = 0; r < R; r++) begin
                tx_buf[r*W_Y_OUT +: W_Y_OUT] <= W_Y_OUT'($signed(y_data[r*W_Y +: W_Y]));
            end
        end
    end

    // TX byte select; tx_cnt only moves on a handshake so m_data holds under stall.
    always_comb begin
        m_data = '0;
        for (int unsigned i = 0; i < N_WORDS_Y; i++) begin
            if (tx_cnt == TX_CNT_W'(i)) begin
                m_data = tx_buf[i*BITS_PER_WORD +: BITS_PER_WORD];
            end
        end
    end

endmodule

// File: tb/tb_mvm_uart_ctrl.sv
// tb_mvm_uart_ctrl
//
// Directed bench for mvm_uart_ctrl with default geometry and TIMEOUT=16.
// A table of full transactions (operand seed, engine stall, result rows,
// TX stall point, expected byte stream) is replayed in a loop; hand-written
// sequences then cover timeout abort, the timeout/accept tie, reset in TX
// and RX back-pressure while the frame is being processed.

module tb_mvm_uart_ctrl;

    localparam int R    = 4;
    localparam int W_Y  = 18;
    localparam int W_KX = 160;
    localparam int NKX  = 20;
    localparam int NY   = 16;

    logic               clk;
    logic               rst;
    logic               s_valid;
    logic [7:0]         s_data;
    logic               s_ready;
    logic               kx_valid;
    logic [W_KX-1:0]    kx_data;
    logic               kx_ready;
    logic               y_valid;
    logic [R*W_Y-1:0]   y_data;
    logic               y_ready;
    logic               m_valid;
    logic [7:0]         m_data;
    logic               m_ready;
    logic               busy;
    logic               err;

    mvm_uart_ctrl #(
        .R(4), .C(4), .W_X(8), .W_K(8), .W_Y_OUT(32),
        .BITS_PER_WORD(8), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .kx_valid(kx_valid), .kx_data(kx_data), .kx_ready(kx_ready),
        .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int err_cnt = 0;
    int acc_cnt = 0;

    // background event counters sampled at the active edge
    always @(posedge clk) begin
        if (err) err_cnt++;
        if (s_valid && s_ready) acc_cnt++;
    end

    typedef struct {
        logic [7:0]       seed;
        int               kx_delay;
        logic [R*W_Y-1:0] y;
        int               stall_at;
        logic [127:0]     exp;
    } vec_t;

    vec_t tbl[3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] kx_model(input logic [7:0] seed);
        logic [159:0] v;
        v = '0;
        for (int i = 0; i < NKX; i++) v[i*8 +: 8] = seed + 8'(i);
        return v;
    endfunction

    task automatic send_bytes(input logic [7:0] seed, input int first, input int last,
                              input bit keep, input logic [7:0] idle_data);
        int guard;
        for (int i = first; i <= last; i++) begin
            s_valid = 1'b1;
            s_data  = seed + 8'(i);
            guard = 0;
            while (!s_ready && guard < 500) begin
                tick();
                guard++;
            end
            if (!s_ready) check("s_ready_wait", 0, 1);
            tick();
        end
        s_valid = keep;
        s_data  = idle_data;
    endtask

    task automatic kx_phase(input logic [7:0] seed, input int delay);
        check("kx_valid_on", kx_valid, 1);
        check("kx_data", kx_data, kx_model(seed));
        if (delay > 0) begin
            kx_ready = 1'b0;
            repeat (delay) tick();
            check("kx_valid_hold", kx_valid, 1);
            check("kx_data_hold", kx_data, kx_model(seed));
            kx_ready = 1'b1;
        end
        tick();
        check("kx_valid_one_beat", {kx_valid, y_ready}, 2'b01);
    endtask

    task automatic y_phase(input logic [R*W_Y-1:0] yd);
        int guard;
        y_valid = 1'b1;
        y_data  = yd;
        guard = 0;
        while (!y_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (!y_ready) check("y_ready_wait", 0, 1);
        tick();
        y_valid = 1'b0;
        check("m_valid_latency", {m_valid, y_ready}, 2'b10);
    endtask

    task automatic tx_phase(input int stall_at, input int stop_after,
                            output logic [127:0] got, output int n);
        int guard;
        logic [7:0] d;
        bit bad;
        got = '0;
        n = 0;
        guard = 0;
        while (n < stop_after && guard < 400) begin
            if (m_valid) begin
                if (n == stall_at) begin
                    m_ready = 1'b0;
                    d = m_data;
                    bad = 1'b0;
                    repeat (5) begin
                        tick();
                        if (m_data !== d || !m_valid) bad = 1'b1;
                    end
                    m_ready = 1'b1;
                    check("m_data_stall_hold", bad, 0);
                end
                got[n*8 +: 8] = m_data;
                n++;
            end
            tick();
            guard++;
        end
    endtask

    task automatic finish_vec(input vec_t v, input string tag);
        logic [127:0] got;
        int n;
        kx_phase(v.seed, v.kx_delay);
        y_phase(v.y);
        tx_phase(v.stall_at, NY, got, n);
        check({tag, "_tx_count"}, n, NY);
        check({tag, "_tx_bytes"}, got, v.exp);
        check({tag, "_back_to_rx"}, {m_valid, busy, s_ready}, 3'b001);
    endtask

    logic [127:0] got5;
    int n5;
    int e0;
    int a0;
    int mv;
    vec_t v;

    initial begin
        tbl[0] = '{seed: 8'h00, kx_delay: 0,
                   y: {18'h00001, 18'h00001, 18'h00001, 18'h3FFFF}, stall_at: -1,
                   exp: 128'h00000001_00000001_00000001_FFFFFFFF};
        tbl[1] = '{seed: 8'h40, kx_delay: 3,
                   y: {18'h12345, 18'h00000, 18'h20000, 18'h1FFFF}, stall_at: 3,
                   exp: 128'h00012345_00000000_FFFE0000_0001FFFF};
        tbl[2] = '{seed: 8'hF5, kx_delay: 1,
                   y: {18'h0FFFF, 18'h3FF00, 18'h00080, 18'h2ABCD}, stall_at: 15,
                   exp: 128'h0000FFFF_FFFFFF00_00000080_FFFEABCD};

        rst = 1'b1; s_valid = 1'b0; s_data = '0; kx_ready = 1'b1;
        y_valid = 1'b0; y_data = '0; m_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("reset_outputs", {s_ready, kx_valid, y_ready, m_valid, err, busy}, 6'b100000);

        for (int i = 0; i < 3; i++) begin
            send_bytes(tbl[i].seed, 0, NKX-1, 1'b0, 8'h00);
            finish_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // partial frame left idle long enough to abort
        e0 = err_cnt;
        send_bytes(8'h20, 0, 6, 1'b0, 8'h00);
        check("busy_partial", busy, 1);
        repeat (20) tick();
        check("timeout_err_once", err_cnt - e0, 1);
        check("timeout_idle", busy, 0);
        send_bytes(tbl[0].seed, 0, NKX-1, 1'b0, 8'h00);
        finish_vec(tbl[0], "after_timeout");

        // byte lands exactly on the cycle the idle count would expire
        e0 = err_cnt;
        send_bytes(8'h80, 0, 2, 1'b0, 8'h00);
        repeat (15) tick();
        send_bytes(8'h80, 3, NKX-1, 1'b0, 8'h00);
        check("tie_no_err", err_cnt - e0, 0);
        v = tbl[1];
        v.seed = 8'h80;
        finish_vec(v, "tie");

        // reset after five TX bytes
        send_bytes(8'h55, 0, NKX-1, 1'b0, 8'h00);
        kx_phase(8'h55, 0);
        y_phase(tbl[0].y);
        tx_phase(-1, 5, got5, n5);
        check("pre_reset_bytes", got5[39:0], tbl[0].exp[39:0]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("reset_in_tx", {m_valid, busy, s_ready}, 3'b001);
        mv = 0;
        repeat (10) begin
            tick();
            if (m_valid) mv++;
        end
        check("no_tx_after_reset", mv, 0);
        send_bytes(tbl[2].seed, 0, NKX-1, 1'b0, 8'h00);
        finish_vec(tbl[2], "after_reset");

        // s_valid kept high through REQ/WAIT_Y/TX
        send_bytes(8'h10, 0, NKX-1, 1'b1, 8'h30);
        a0 = acc_cnt;
        v = tbl[0];
        v.seed = 8'h10;
        v.kx_delay = 2;
        finish_vec(v, "hold_f1");
        check("no_accept_outside_rx", acc_cnt - a0, 0);
        send_bytes(8'h30, 0, NKX-1, 1'b0, 8'h00);
        v = tbl[1];
        v.seed = 8'h30;
        finish_vec(v, "hold_f2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
